// File: rtl/lb_loopback_emu_pkg.sv
// Shared defaults, per-channel configuration record and delay clamp for the
// DAC-to-ADC loopback emulator.
package lb_loopback_emu_pkg;

   localparam int DEF_NCH    = 8;
   localparam int DEF_DW     = 16;
   localparam int DEF_MAXDLY = 64;
   localparam int DEF_DLYW   = $clog2(DEF_MAXDLY);
   localparam int DEF_SHW    = $clog2(DEF_DW);

   typedef struct packed {
      logic                enable;
      logic [DEF_SHW-1:0]  shift;
      logic [DEF_DLYW-1:0] delay;
   } cfg_t;

   // Requests deeper than the delay line saturate at the oldest stored sample.
   function automatic logic [DEF_DLYW-1:0] clamp_delay(input logic [DEF_DLYW+1:0] req);
      logic [DEF_DLYW-1:0] v;
      if (req > (DEF_DLYW+2)'(DEF_MAXDLY - 32'd1)) begin
         v = (DEF_DLYW)'(DEF_MAXDLY - 32'd1);
      end else begin
         v = req[DEF_DLYW-1:0];
      end
      return v;
   endfunction

endpackage

// File: rtl/lb_loopback_chan.sv
// One loopback channel: delay-line RAM with registered read, config and mute
// counter, then arithmetic attenuation and output gating.
module lb_loopback_chan
   import lb_loopback_emu_pkg::*;
#(
   parameter  int DW     = DEF_DW,
   parameter  int MAXDLY = DEF_MAXDLY,
   localparam int DLYW   = $clog2(MAXDLY)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DLYW-1:0] i_wptr,
   input  logic [DW-1:0]   i_din,
   input  logic            i_cfg_we,
   input  cfg_t            i_cfg,
   output logic [DW-1:0]   o_dout,
   output logic            o_muted
);

   logic [DW-1:0]        r_ram [MAXDLY];
   logic [DW-1:0]        r_rd;
   cfg_t                 r_cfg;
   logic [DLYW:0]        r_cnt;
   cfg_t                 w_cfg_nxt;
   logic [DLYW:0]        w_cnt_nxt;
   logic                 w_gate_nxt;
   logic [DLYW-1:0]      w_raddr;
   logic signed [DW-1:0] w_shifted;

   assign w_raddr   = i_wptr - r_cfg.delay;
   assign w_shifted = $signed(r_rd) >>> r_cfg.shift;

   // Next config/mute state; the gate is evaluated on it so muted lines up with dout.
   always_comb begin
      w_cfg_nxt = r_cfg;
      w_cnt_nxt = r_cnt;
      if (i_cfg_we) begin
         w_cfg_nxt = i_cfg;
         w_cnt_nxt = {1'b0, i_cfg.delay} + (DLYW+1)'(32'd2);
      end else if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - (DLYW+1)'(32'd1);
      end else begin
         w_cnt_nxt = r_cnt;
      end
      w_gate_nxt = !w_cfg_nxt.enable || (w_cnt_nxt != '0);
   end

   // Delay-line write, one sample per cycle, contents deliberately not reset.
   always_ff @(posedge clk) begin
      r_ram[i_wptr] <= i_din;
   end

   // Stage 1: delay 0 would read the slot being written this edge, so bypass it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd <= '0;
      end else if (r_cfg.delay == '0) begin
         r_rd <= i_din;
      end else begin
         r_rd <= r_ram[w_raddr];
      end
   end

   // Stage 2 plus config and mute counter state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cfg   <= '0;
         r_cnt   <= (DLYW+1)'(32'd2);
         o_dout  <= '0;
         o_muted <= 1'b1;
      end else begin
         r_cfg   <= w_cfg_nxt;
         r_cnt   <= w_cnt_nxt;
         o_muted <= w_gate_nxt;
         o_dout  <= w_gate_nxt ? '0 : w_shifted;
      end
   end

endmodule

// File: rtl/lb_loopback_emu.sv
// Top of the loopback emulator: shared write pointer, config channel decode
// and one lb_loopback_chan per DAC/ADC lane.
module lb_loopback_emu
   import lb_loopback_emu_pkg::*;
#(
   parameter  int NCH    = DEF_NCH,
   parameter  int DW     = DEF_DW,
   parameter  int MAXDLY = DEF_MAXDLY,
   localparam int DLYW   = $clog2(MAXDLY),
   localparam int SHW    = $clog2(DW),
   // Extra bit on channel and delay so out-of-range requests reach the decode/clamp.
   localparam int CHW    = $clog2(NCH) + 1,
   localparam int CDW    = DLYW + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*DW-1:0] din,
   output logic [NCH*DW-1:0] dout,
   input  logic              cfg_wvalid,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [CDW-1:0]    cfg_delay,
   input  logic [SHW-1:0]    cfg_shift,
   input  logic              cfg_enable,
   output logic [NCH-1:0]    muted
);

   logic [DLYW-1:0] r_wptr;
   cfg_t            w_cfg;

   assign w_cfg.enable = cfg_enable;
   assign w_cfg.shift  = cfg_shift;
   assign w_cfg.delay  = clamp_delay(cfg_delay);

   // Shared write pointer; the power-of-two depth makes the wrap free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
      end else begin
         r_wptr <= r_wptr + DLYW'(32'd1);
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      logic w_we;
      assign w_we = cfg_wvalid && (cfg_ch == CHW'(k));

      lb_loopback_chan #(
         .DW     (DW),
         .MAXDLY (MAXDLY)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .i_wptr   (r_wptr),
         .i_din    (din[k*DW +: DW]),
         .i_cfg_we (w_we),
         .i_cfg    (w_cfg),
         .o_dout   (dout[k*DW +: DW]),
         .o_muted  (muted[k])
      );
   end

endmodule
